// File: rtl/rcn_pkg.sv
// Shared definitions for the RCN ring: slot field positions and slave FSM encoding.
package rcn_pkg;

  localparam int RCN_VALID   = 63;
  localparam int RCN_PEND    = 62;
  localparam int RCN_WR      = 61;
  localparam int RCN_ID_HI   = 60;
  localparam int RCN_ID_LO   = 55;
  localparam int RCN_MASK_HI = 54;
  localparam int RCN_MASK_LO = 51;
  localparam int RCN_ADDR_HI = 50;
  localparam int RCN_ADDR_LO = 32;
  localparam int RCN_DATA_HI = 31;
  localparam int RCN_DATA_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } rcn_state_t;

endpackage

// File: rtl/rcn_slave_node.sv
// RCN ring responder: consumes requests hitting its address window, runs them on the
// local CS/ACK port, then drops the response into the first empty ring slot.
module rcn_slave_node
  import rcn_pkg::*;
#(
  parameter logic [18:0] ADDR_BASE = 19'h00000,
  parameter logic [18:0] ADDR_MASK = 19'h7FF00
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [63:0] RCN_IN,
  output logic [63:0] RCN_OUT,
  output logic        CS,
  output logic        WE,
  output logic [18:0] ADDR,
  output logic [3:0]  WMASK,
  output logic [31:0] WDATA,
  input  logic [31:0] RDATA,
  input  logic        ACK
);

  // Local port handshake: CS rises with a latched request and stays high until a
  // single-cycle ACK; ACK outside CS is meaningless and ignored.
  rcn_state_t  state, state_d;
  logic [63:0] rcn_q, rcn_d;
  logic        cs_q, cs_d;
  logic        we_q, we_d;
  logic [5:0]  id_q, id_d;
  logic [3:0]  mask_q, mask_d;
  logic [18:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        hit;

  assign hit = RCN_IN[RCN_VALID] & RCN_IN[RCN_PEND] &
               ((RCN_IN[RCN_ADDR_HI:RCN_ADDR_LO] & ADDR_MASK) == (ADDR_BASE & ADDR_MASK));

  always_comb begin
    state_d = state;
    rcn_d   = RCN_IN;
    cs_d    = cs_q;
    we_d    = we_q;
    id_d    = id_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state)
      ST_IDLE: begin
        if (hit) begin
          we_d    = RCN_IN[RCN_WR];
          id_d    = RCN_IN[RCN_ID_HI:RCN_ID_LO];
          mask_d  = RCN_IN[RCN_MASK_HI:RCN_MASK_LO];
          addr_d  = RCN_IN[RCN_ADDR_HI:RCN_ADDR_LO];
          data_d  = RCN_IN[RCN_DATA_HI:RCN_DATA_LO];
          rcn_d   = '0;
          cs_d    = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Writes answer with the data they wrote, so data_q is only replaced on reads.
        if (ACK) begin
          if (!we_q) data_d = RDATA;
          cs_d    = 1'b0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (!RCN_IN[RCN_VALID]) begin
          rcn_d   = {1'b1, 1'b0, we_q, id_q, mask_q, addr_q, data_q};
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_IDLE;
      rcn_q  <= '0;
      cs_q   <= 1'b0;
      we_q   <= 1'b0;
      id_q   <= '0;
      mask_q <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state  <= state_d;
      rcn_q  <= rcn_d;
      cs_q   <= cs_d;
      we_q   <= we_d;
      id_q   <= id_d;
      mask_q <= mask_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign RCN_OUT = rcn_q;
  assign CS      = cs_q;
  assign WE      = we_q;
  assign ADDR    = addr_q;
  assign WMASK   = mask_q;
  assign WDATA   = data_q;

endmodule

// File: tb/tb_rcn_slave_node.sv
// Bench for rcn_slave_node: vector table for reset/miss/read/write flows plus
// hand-written busy-ring and mid-operation reset sequences.
module tb_rcn_slave_node;

  logic        CLK;
  logic        RST;
  logic [63:0] RCN_IN;
  logic [63:0] RCN_OUT;
  logic        CS;
  logic        WE;
  logic [18:0] ADDR;
  logic [3:0]  WMASK;
  logic [31:0] WDATA;
  logic [31:0] RDATA;
  logic        ACK;

  int n_cmp;
  int n_err;
  logic [63:0] exp_q[$];

  rcn_slave_node dut (
    .CLK(CLK), .RST(RST), .RCN_IN(RCN_IN), .RCN_OUT(RCN_OUT),
    .CS(CS), .WE(WE), .ADDR(ADDR), .WMASK(WMASK), .WDATA(WDATA),
    .RDATA(RDATA), .ACK(ACK)
  );

  // Clock / reset block
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic [63:0] rin;
    logic        ack;
    logic [31:0] rdata;
    logic [63:0] eout;
    logic        ecs;
    logic        ewe;
    logic [18:0] eaddr;
    logic [3:0]  emask;
    logic [31:0] ewdata;
  } vec_t;

  vec_t vt[14];

  function automatic logic [63:0] mk(input logic v, input logic p, input logic w,
                                     input logic [5:0] id, input logic [3:0] m,
                                     input logic [18:0] a, input logic [31:0] d);
    return {v, p, w, id, m, a, d};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver: apply one ring slot, push its expected output, clock, then score it.
  task automatic cyc(input logic rst_i, input logic [63:0] in_i, input logic ack_i,
                     input logic [31:0] rd_i, input logic [63:0] exp_i, input string name);
    logic [63:0] e;
    RST    = rst_i;
    RCN_IN = in_i;
    ACK    = ack_i;
    RDATA  = rd_i;
    exp_q.push_back(exp_i);
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    chk(name, RCN_OUT, e);
  endtask

  function automatic logic [63:0] occ();
    logic [63:0] r;
    r = {$urandom, $urandom};
    r[63] = 1'b1;
    return r;
  endfunction

  logic [63:0] ones, req_miss, req_rd, req_wr, h1, h2, h3, h4, o;

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    RST    = 1'b1;
    RCN_IN = '0;
    ACK    = 1'b0;
    RDATA  = '0;

    ones     = '1;
    req_miss = mk(1, 1, 0, 6'd3, 4'hF, 19'h12345, 32'hCAFE_0001);
    req_rd   = mk(1, 1, 0, 6'd5, 4'hF, 19'h00010, 32'h1111_2222);
    req_wr   = mk(1, 1, 1, 6'd9, 4'b0011, 19'h00040, 32'hA5A5_0000);

    vt[0]  = '{1'b1, ones,     1'b0, 32'h0, 64'h0,     1'b0, 1'b0, 19'h0,  4'h0, 32'h0};
    vt[1]  = '{1'b1, ones,     1'b0, 32'h0, 64'h0,     1'b0, 1'b0, 19'h0,  4'h0, 32'h0};
    vt[2]  = '{1'b0, ones,     1'b0, 32'h0, ones,      1'b0, 1'b0, 19'h0,  4'h0, 32'h0};
    vt[3]  = '{1'b0, req_miss, 1'b0, 32'h0, req_miss,  1'b0, 1'b0, 19'h0,  4'h0, 32'h0};
    vt[4]  = '{1'b0, 64'h0,    1'b0, 32'h0, 64'h0,     1'b0, 1'b0, 19'h0,  4'h0, 32'h0};
    vt[5]  = '{1'b0, req_rd,   1'b0, 32'h0, 64'h0,     1'b1, 1'b0, 19'h10, 4'hF, 32'h1111_2222};
    vt[6]  = '{1'b0, 64'h0,    1'b0, 32'h0, 64'h0,     1'b1, 1'b0, 19'h10, 4'hF, 32'h1111_2222};
    vt[7]  = '{1'b0, 64'h0,    1'b0, 32'h0, 64'h0,     1'b1, 1'b0, 19'h10, 4'hF, 32'h1111_2222};
    vt[8]  = '{1'b0, 64'h0,    1'b1, 32'hDEAD_BEEF, 64'h0, 1'b0, 1'b0, 19'h0, 4'h0, 32'h0};
    vt[9]  = '{1'b0, 64'h0,    1'b0, 32'h0,
               mk(1, 0, 0, 6'd5, 4'hF, 19'h00010, 32'hDEAD_BEEF), 1'b0, 1'b0, 19'h0, 4'h0, 32'h0};
    vt[10] = '{1'b0, 64'h0,    1'b1, 32'h7777_7777, 64'h0, 1'b0, 1'b0, 19'h0, 4'h0, 32'h0};
    vt[11] = '{1'b0, req_wr,   1'b0, 32'h0, 64'h0,     1'b1, 1'b1, 19'h40, 4'h3, 32'hA5A5_0000};
    vt[12] = '{1'b0, 64'h0,    1'b1, 32'hFFFF_FFFF, 64'h0, 1'b0, 1'b0, 19'h0, 4'h0, 32'h0};
    vt[13] = '{1'b0, 64'h0,    1'b0, 32'h0,
               mk(1, 0, 1, 6'd9, 4'b0011, 19'h00040, 32'hA5A5_0000), 1'b0, 1'b0, 19'h0, 4'h0, 32'h0};

    for (int i = 0; i < 14; i++) begin
      cyc(vt[i].rst, vt[i].rin, vt[i].ack, vt[i].rdata, vt[i].eout, $sformatf("vec%0d_rcn_out", i));
      chk($sformatf("vec%0d_cs", i), {63'h0, CS}, {63'h0, vt[i].ecs});
      if (vt[i].ecs) begin
        chk($sformatf("vec%0d_we", i), {63'h0, WE}, {63'h0, vt[i].ewe});
        chk($sformatf("vec%0d_addr", i), {45'h0, ADDR}, {45'h0, vt[i].eaddr});
        chk($sformatf("vec%0d_wmask", i), {60'h0, WMASK}, {60'h0, vt[i].emask});
        chk($sformatf("vec%0d_wdata", i), {32'h0, WDATA}, {32'h0, vt[i].ewdata});
      end
    end

    // Busy slave lets a second hit circulate; response waits out a full ring.
    h1 = mk(1, 1, 0, 6'd2, 4'hF, 19'h00020, 32'h0);
    h2 = mk(1, 1, 1, 6'd7, 4'h1, 19'h00030, 32'h0000_0055);
    cyc(1'b0, h1, 1'b0, 32'h0, 64'h0, "busy_consume");
    chk("busy_cs_up", {63'h0, CS}, 64'h1);
    cyc(1'b0, h2, 1'b0, 32'h0, h2, "busy_second_hit_pass");
    chk("busy_cs_held", {63'h0, CS}, 64'h1);
    o = occ();
    cyc(1'b0, o, 1'b1, 32'h1234_5678, o, "busy_ack_slot_pass");
    chk("busy_cs_drop", {63'h0, CS}, 64'h0);
    for (int k = 0; k < 5; k++) begin
      o = occ();
      cyc(1'b0, o, 1'b0, 32'h0, o, $sformatf("resp_full_%0d", k));
    end
    cyc(1'b0, 64'h0, 1'b0, 32'h0, mk(1, 0, 0, 6'd2, 4'hF, 19'h00020, 32'h1234_5678), "resp_insert");
    cyc(1'b0, 64'h0, 1'b0, 32'h0, 64'h0, "after_insert_idle");

    // Reset during BUSY drops the transaction for good.
    h3 = mk(1, 1, 0, 6'd1, 4'h8, 19'h00044, 32'h0);
    cyc(1'b0, h3, 1'b0, 32'h0, 64'h0, "rst_mid_consume");
    chk("rst_mid_cs_up", {63'h0, CS}, 64'h1);
    cyc(1'b1, 64'h0, 1'b0, 32'h0, 64'h0, "rst_mid_out");
    chk("rst_mid_cs_low", {63'h0, CS}, 64'h0);
    cyc(1'b0, 64'h0, 1'b1, 32'h5555_AAAA, 64'h0, "rst_mid_no_resp0");
    for (int k = 1; k < 4; k++)
      cyc(1'b0, 64'h0, 1'b0, 32'h0, 64'h0, $sformatf("rst_mid_no_resp%0d", k));
    h4 = mk(1, 1, 0, 6'd4, 4'hF, 19'h00050, 32'h0);
    cyc(1'b0, h4, 1'b0, 32'h0, 64'h0, "post_rst_consume");
    chk("post_rst_cs", {63'h0, CS}, 64'h1);
    chk("post_rst_addr", {45'h0, ADDR}, {45'h0, 19'h00050});
    cyc(1'b0, 64'h0, 1'b1, 32'h0BAD_F00D, 64'h0, "post_rst_ack");
    cyc(1'b0, 64'h0, 1'b0, 32'h0, mk(1, 0, 0, 6'd4, 4'hF, 19'h00050, 32'h0BAD_F00D), "post_rst_resp");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
